cdb_arbiter: RTL

Common data bus (CDB) arbiter between the functional units and the reservation station. Each result-producing FU class pushes completed results (destination physical-register tag plus value) into a small per-source FIFO. Each cycle the arbiter grants one non-empty source, chosen round-robin. It drives a single registered CDB broadcast that feeds the reservation station's `update`/`ready_reg` wakeup port and the register file write port.

---
 rtl/cdb_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Common data bus arbiter. Each result source (ALU, MULT, LOAD, STORE,
// BRANCH) pushes {tag, data} into its own small FIFO. Each cycle one
// non-empty source is granted round-robin, and its head is loaded into a
// registered CDB broadcast. That broadcast feeds RS wakeup and the register
// file write port.
//
// Handshake: source i transfers a result on a clock edge where
// req_valid[i] && req_ready[i]. req_ready[i] depends on registered FIFO
// occupancy only (a same-cycle pop is not credited), and a req_valid
// without req_ready is ignored.
//
// Ports:
//   clock, reset       sole clock; synchronous active-high reset
//   flush              empties all FIFOs and cancels the pending broadcast
//   req_valid/tag/data per-source result inputs (packed, source i at slice i)
//   req_ready          per-source FIFO has room
//   cdb_valid/tag/data registered broadcast
//   cdb_src            index of the source that produced the broadcast
//   free_src           combinational one-hot of this cycle's grant
//
// Optional feature macro: CDB_BYPASS_EN. When defined, an empty FIFO whose
// source presents req_valid is eligible this cycle. If it wins, its input is
// broadcast directly and is never written into the FIFO.
module cdb_arbiter #(
  parameter int NUM_SRC = 5,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_SRC-1:0]           req_valid,
  input  logic [NUM_SRC*TAG_W-1:0]     req_tag,
  input  logic [NUM_SRC*DATA_W-1:0]    req_data,
  output logic [NUM_SRC-1:0]           req_ready,
  output logic                         cdb_valid,
  output logic [TAG_W-1:0]             cdb_tag,
  output logic [DATA_W-1:0]            cdb_data,
  output logic [$clog2(NUM_SRC)-1:0]   cdb_src,
  output logic [NUM_SRC-1:0]           free_src
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Per-source FIFO state
  logic [CNT_W-1:0]  count    [NUM_SRC];
  logic [PTR_W-1:0]  rd_ptr   [NUM_SRC];
  logic [PTR_W-1:0]  wr_ptr   [NUM_SRC];
  logic [TAG_W-1:0]  tag_mem  [NUM_SRC][DEPTH];
  logic [DATA_W-1:0] data_mem [NUM_SRC][DEPTH];

  // Round-robin pointer: index with highest priority this cycle
  logic [SRC_W-1:0]  rr;

  logic [NUM_SRC-1:0] not_empty;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] write_en;
  logic [NUM_SRC-1:0] pop;
  logic               found;
  logic               grant;
  logic [SRC_W-1:0]   gnt_idx;
  logic [TAG_W-1:0]   head_tag;
  logic [DATA_W-1:0]  head_data;

  // Occupancy, readiness and eligibility
  always_comb begin
    not_empty = '0;
    eligible  = '0;
    req_ready = '0;
    push      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      not_empty[i] = (count[i] != '0);
      req_ready[i] = (count[i] < DEPTH_C);
      push[i]      = req_valid[i] && req_ready[i];
`ifdef CDB_BYPASS_EN
      eligible[i]  = not_empty[i] || req_valid[i];
`else
      eligible[i]  = not_empty[i];
`endif
    end
  end

  // Round-robin scan starting at rr, wrapping past NUM_SRC-1 to 0
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && eligible[idx]) begin
        found   = 1'b1;
        gnt_idx = SRC_W'(idx);
      end
    end
    // Flush and reset squash the grant so nothing pops and free_src stays 0
    grant = found && !flush && !reset;
  end

  // Candidate payload: FIFO head, or the raw input when a bypass wins
  always_comb begin
    head_tag  = tag_mem[gnt_idx][rd_ptr[gnt_idx]];
    head_data = data_mem[gnt_idx][rd_ptr[gnt_idx]];
`ifdef CDB_BYPASS_EN
    if (!not_empty[gnt_idx]) begin
      head_tag  = req_tag[gnt_idx*TAG_W +: TAG_W];
      head_data = req_data[gnt_idx*DATA_W +: DATA_W];
    end
`endif
  end

  // Per-source pop / write strobes and the grant one-hot
  always_comb begin
    pop      = '0;
    write_en = '0;
    free_src = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      free_src[i] = grant && (gnt_idx == SRC_W'(i));
      pop[i]      = free_src[i] && not_empty[i];
      // A bypassed winner is consumed straight from the input, not stored
      write_en[i] = push[i] && !(free_src[i] && !not_empty[i]);
    end
  end

  // FIFO storage (no reset needed: occupancy gates every read)
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!reset && !flush && write_en[i]) begin
        tag_mem[i][wr_ptr[i]]  <= req_tag[i*TAG_W +: TAG_W];
        data_mem[i][wr_ptr[i]] <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Control state and broadcast register
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      rr        <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        // Pointers wrap naturally because DEPTH is a power of two
        if (write_en[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])      rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        case ({write_en[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
      if (grant) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= head_tag;
        cdb_data  <= head_data;
        cdb_src   <= gnt_idx;
        if (int'(gnt_idx) == NUM_SRC - 1) rr <= '0;
        else                              rr <= gnt_idx + SRC_W'(1);
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule
